// File: rtl/gray_step_ctrl_pkg.sv
// Shared state encoding, default widths and a bit-change helper for the Gray step controller.
// Imported by gray_next and gray_step_ctrl.
package gray_step_pkg;

  localparam int WIDTH_DEF = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when exactly one bit of the difference vector is set.
  function automatic logic single_bit_change(input logic [31:0] diff);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + int'(diff[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/gray_step_ctrl_gray_next.sv
// Combinational next-Gray-code generator: decode to binary, step up or down, re-encode.
// Instanced once by gray_step_ctrl.
module gray_next
  import gray_step_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] g,
  input  logic             dir,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] bin_step_s;

  // Binary bit i is the XOR of Gray bits i..MSB.
  always_comb begin
    bin_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_s[i] = ^(g >> i);
    end
  end

  // Modular step in binary, then back to Gray.
  always_comb begin
    if (dir) begin
      bin_step_s = bin_s + ONE;
    end else begin
      bin_step_s = bin_s - ONE;
    end
    next = bin_step_s ^ (bin_step_s >> 1);
  end

endmodule

// File: rtl/gray_step_ctrl.sv
// Gray position sequencer: runs N Gray steps up/down with pause, preload and done/wrap pulses.
// Optional GRAY_STEP_CHK_EN adds a sticky err output flagging any non-single-bit step.
module gray_step_ctrl
  import gray_step_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_q,
`ifdef GRAY_STEP_CHK_EN
  output logic             err,
`endif
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // Gray code of binary max (MSB only) and of binary 0 bound the wrap crossing.
  localparam logic [WIDTH-1:0] GRAY_MAX  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] GRAY_ZERO = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] remaining_r, remaining_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic             armed_r, armed_nxt_s;
  logic [WIDTH-1:0] gray_r, gray_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             step_s;
  logic             wrap_cross_s;
  logic [WIDTH-1:0] next_gray_s;

  gray_next #(.WIDTH(WIDTH)) u_gray_next (
    .g    (gray_r),
    .dir  (dir_r),
    .next (next_gray_s)
  );

  // A step crosses the binary boundary when leaving max going up or leaving 0 going down.
  always_comb begin
    if (dir_r) begin
      wrap_cross_s = (gray_r == GRAY_MAX);
    end else begin
      wrap_cross_s = (gray_r == GRAY_ZERO);
    end
  end

  // Next-state and registered-output decode. The first RUN cycle after start never steps,
  // which places the first step two edges after start is sampled.
  always_comb begin
    state_nxt_s     = state_r;
    remaining_nxt_s = remaining_r;
    dir_nxt_s       = dir_r;
    armed_nxt_s     = armed_r;
    gray_nxt_s      = gray_r;
    busy_nxt_s      = 1'b0;
    done_nxt_s      = 1'b0;
    wrap_nxt_s      = 1'b0;
    step_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          gray_nxt_s = load_val;
        end else begin
          gray_nxt_s = gray_r;
        end
        if (start && (steps != CNT_ZERO)) begin
          remaining_nxt_s = steps;
          dir_nxt_s       = dir;
          armed_nxt_s     = 1'b0;
          busy_nxt_s      = 1'b1;
          state_nxt_s     = ST_RUN;
        end else if (start) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pause) begin
          armed_nxt_s = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (!armed_r) begin
          armed_nxt_s = 1'b1;
          busy_nxt_s  = 1'b1;
        end else begin
          step_s          = 1'b1;
          gray_nxt_s      = next_gray_s;
          wrap_nxt_s      = wrap_cross_s;
          remaining_nxt_s = remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            busy_nxt_s = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        busy_nxt_s = 1'b1;
        if (!pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= CNT_ZERO;
      dir_r       <= 1'b1;
      armed_r     <= 1'b0;
      gray_r      <= GRAY_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= remaining_nxt_s;
      dir_r       <= dir_nxt_s;
      armed_r     <= armed_nxt_s;
      gray_r      <= gray_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      wrap_r      <= wrap_nxt_s;
    end
  end

`ifdef GRAY_STEP_CHK_EN
  logic err_r;

  // Sticky flag: any RUN-state update that does not flip exactly one bit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_r <= 1'b0;
    end else if (step_s && !single_bit_change(32'(gray_r ^ next_gray_s))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

  assign gray_q = gray_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Scoreboard bench for gray_step_ctrl: a binary-position reference model queues expected
// outputs each cycle; an independent monitor pops and compares after every clock edge.
module tb_gray_step_ctrl;

  localparam int W  = 3;
  localparam int CW = 8;
  localparam int MODV = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n, start, dir, pause, load;
  logic [CW-1:0] steps;
  logic [W-1:0]  load_val;
  logic [W-1:0]  gray_q;
  logic          busy, done, wrap;
`ifdef GRAY_STEP_CHK_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  gray_step_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir      (dir),
    .steps    (steps),
    .pause    (pause),
    .load     (load),
    .load_val (load_val),
    .gray_q   (gray_q),
`ifdef GRAY_STEP_CHK_EN
    .err      (err),
`endif
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  typedef struct {
    logic [W-1:0] g;
    logic         b;
    logic         d;
    logic         w;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stop_mon = 1'b0;

  function automatic int g2b(input logic [W-1:0] g);
    int b;
    b = 0;
    for (int i = W - 1; i >= 0; i--) begin
      b = (b << 1) | ((b & 1) ^ int'(g[i]));
    end
    return b;
  endfunction

  // Reference model: position kept as a plain binary integer, Gray derived on output.
  initial begin
    int pos, rem;
    bit up, active, held, fresh, fin, wrapf;
    exp_t e;
    pos = 0; rem = 0; up = 1; active = 0; held = 0; fresh = 0; fin = 0;
    forever begin
      @(posedge clk);
      wrapf = 0;
      if (rst_n) begin
        pos = 0; rem = 0; up = 1; active = 0; held = 0; fresh = 0; fin = 0;
      end else if (fin) begin
        fin = 0;
      end else if (!active) begin
        if (load) pos = g2b(load_val);
        if (start) begin
          if (steps == 0) fin = 1;
          else begin
            active = 1; rem = int'(steps); up = dir; fresh = 1; held = 0;
          end
        end
      end else if (held) begin
        if (!pause) held = 0;
      end else if (pause) begin
        held = 1; fresh = 0;
      end else if (fresh) begin
        fresh = 0;
      end else begin
        if (up) begin
          pos = (pos + 1) % MODV; wrapf = (pos == 0);
        end else begin
          pos = (pos + MODV - 1) % MODV; wrapf = (pos == MODV - 1);
        end
        rem--;
        if (rem == 0) begin
          active = 0; fin = 1;
        end
      end
      e.g = W'(pos ^ (pos >> 1));
      e.b = active;
      e.d = fin;
      e.w = wrapf;
      q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs shortly after every edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!stop_mon) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
        end else begin
          e = q.pop_front();
          if (gray_q !== e.g) begin
            errors++;
            $display("FAIL gray_q: got %b expected %b at %0t", gray_q, e.g, $time);
          end
          checks++;
          if (busy !== e.b) begin
            errors++;
            $display("FAIL busy: got %b expected %b at %0t", busy, e.b, $time);
          end
          checks++;
          if (done !== e.d) begin
            errors++;
            $display("FAIL done: got %b expected %b at %0t", done, e.d, $time);
          end
          checks++;
          if (wrap !== e.w) begin
            errors++;
            $display("FAIL wrap: got %b expected %b at %0t", wrap, e.w, $time);
          end
`ifdef GRAY_STEP_CHK_EN
          checks++;
          if (err !== 1'b0) begin
            errors++;
            $display("FAIL err: got %b expected 0 at %0t", err, $time);
          end
`endif
        end
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic d, input logic [CW-1:0] n,
                       input logic p, input logic l, input logic [W-1:0] lv);
    @(negedge clk);
    rst_n = r; start = s; dir = d; steps = n; pause = p; load = l; load_val = lv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; dir = 1'b1; steps = 8'd0;
    pause = 1'b0; load = 1'b0; load_val = 3'b000;
    drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 3'b000);
    idle(2);
    // Full up-cycle of 8 steps from 000 with wrap on the last step.
    drive(1'b0, 1'b1, 1'b1, 8'd8, 1'b0, 1'b0, 3'b000);
    idle(12);
    // Preload 110 then count down 3.
    drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 3'b110);
    drive(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 3'b000);
    idle(7);
    // Five steps with a 3-cycle pause after the second step.
    drive(1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 3'b000);
    idle(3);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 3'b000);
    idle(9);
    // Zero-length run.
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 3'b000);
    idle(4);
    // Load and start together.
    drive(1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 3'b101);
    idle(6);
    // Six-step run with ignored start/load while busy, then reset mid-run.
    drive(1'b0, 1'b1, 1'b0, 8'd6, 1'b0, 1'b0, 3'b000);
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 3'b111);
    drive(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 3'b011);
    drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 3'b000);
    idle(4);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            CW'($urandom_range(0, 12)),
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            W'($urandom_range(0, MODV - 1)));
    end
    idle(20);
    @(negedge clk);
    stop_mon = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
